// File: rtl/uart_tx_pkg.sv
// -----------------------------------------------------------------------------
// uart_tx_pkg
//   Shared definitions for the UART transmitter slice:
//     - tx_state_t    : frame sequencer states (IDLE, START, DATA, PARITY, STOP)
//     - PAR_EVEN/ODD  : encoding of the PAR_TYP input
//     - TX_IDLE_LEVEL : level of the serial line when no frame is in flight
//     - parity_bit()  : parity bit from a word's XOR reduction and parity type
// -----------------------------------------------------------------------------
package uart_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_t;

    localparam logic PAR_EVEN       = 1'b0;
    localparam logic PAR_ODD        = 1'b1;

    localparam logic TX_IDLE_LEVEL  = 1'b1;
    localparam logic TX_START_LEVEL = ~TX_IDLE_LEVEL;
    localparam logic TX_STOP_LEVEL  = TX_IDLE_LEVEL;

    // Even parity is the plain XOR of the data bits; odd parity is its
    // complement. Because PAR_EVEN is 0 and PAR_ODD is 1, XOR-ing with the
    // parity type selects between the two.
    function automatic logic parity_bit(input logic xor_reduction,
                                        input logic par_typ);
        return xor_reduction ^ par_typ;
    endfunction

endpackage : uart_tx_pkg

// File: rtl/uart_tx_serializer.sv
// -----------------------------------------------------------------------------
// uart_tx_serializer
//   Shift register plus bit counter for the data portion of a UART frame.
//
//   Ports
//     CLK         in  1           bit-rate clock
//     RST         in  1           asynchronous, active-high reset
//     i_load      in  1           load i_data into the shift register, clear counter
//     i_shift_en  in  1           advance one data bit (asserted every DATA cycle)
//     i_data      in  DATA_WIDTH  word to serialise (from the top's capture regs)
//     o_ser_bit   out 1           data bit the top should register onto the line
//                                 at the coming edge
//     o_ser_done  out 1           the line is currently showing the last data bit
//
//   The counter tracks which data bit is on the line. It wraps from
//   DATA_WIDTH-1 back to 0 on the edge that leaves the data phase.
// -----------------------------------------------------------------------------
module uart_tx_serializer #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  i_load,
    input  logic                  i_shift_en,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic                  o_ser_bit,
    output logic                  o_ser_done
);

    localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(DATA_WIDTH - 1);

    logic [DATA_WIDTH-1:0] r_shift;
    logic [CW-1:0]         r_cnt;
    logic [DATA_WIDTH-1:0] w_next;

    assign w_next = r_shift >> 1;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_shift <= '0;
            r_cnt   <= '0;
        end else if (i_load) begin
            r_shift <= i_data;
            r_cnt   <= '0;
        end else if (i_shift_en) begin
            r_shift <= w_next;
            r_cnt   <= (r_cnt == LAST_IDX) ? '0 : r_cnt + CW'(1);
        end
    end

    // Bit 0 of the shift register is the bit currently on the line during
    // DATA. The top registers TX_OUT, so it needs the bit that will be on the
    // line after the edge: bit 0 from START (no shift yet), the following bit
    // while shifting.
    assign o_ser_bit  = i_shift_en ? w_next[0] : r_shift[0];
    assign o_ser_done = (r_cnt == LAST_IDX);

endmodule : uart_tx_serializer

// File: rtl/uart_tx.sv
// -----------------------------------------------------------------------------
// uart_tx
//   UART transmitter clocked at the bit rate (one CLK per serial bit).
//   Frame: start bit (0), DATA_WIDTH data bits LSB first, optional parity
//   bit, stop bit (1). A request seen in IDLE or in the STOP cycle is
//   accepted; in STOP this gives a back-to-back frame with no idle gap.
//   Requests arriving during START/DATA/PARITY are dropped.
//
//   Ports
//     CLK         in  1           bit-rate clock
//     RST         in  1           asynchronous, active-high reset
//     P_DATA      in  DATA_WIDTH  word to send, captured on an accept edge
//     Data_Valid  in  1           request strobe (pulse or level)
//     PAR_EN      in  1           1 = append a parity bit (captured on accept)
//     PAR_TYP     in  1           0 = even, 1 = odd parity (captured on accept)
//     TX_OUT      out 1           registered serial line, idles high
//     Busy        out 1           registered, high for every frame-bit cycle
// -----------------------------------------------------------------------------
module uart_tx
    import uart_tx_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  Data_Valid,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic                  TX_OUT,
    output logic                  Busy
);

    tx_state_t             r_state;
    logic                  r_tx;
    logic                  r_busy;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_par_en;
    logic                  r_par_typ;

    logic                  w_accept;
    logic                  w_shift_en;
    logic                  w_ser_bit;
    logic                  w_ser_done;
    logic                  w_parity;

    // A new frame may start only when the line is idle or showing its stop bit.
    assign w_accept   = Data_Valid && ((r_state == ST_IDLE) || (r_state == ST_STOP));
    assign w_shift_en = (r_state == ST_DATA);

    // Parity always comes from the captured word, so P_DATA may change freely
    // once the frame has started.
    assign w_parity   = parity_bit(^r_data, r_par_typ);

    // The serializer loads straight from P_DATA on the accept edge, the same
    // edge that fills the capture registers.
    uart_tx_serializer #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_serializer (
        .CLK        (CLK),
        .RST        (RST),
        .i_load     (w_accept),
        .i_shift_en (w_shift_en),
        .i_data     (P_DATA),
        .o_ser_bit  (w_ser_bit),
        .o_ser_done (w_ser_done)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state   <= ST_IDLE;
            r_tx      <= TX_IDLE_LEVEL;
            r_busy    <= 1'b0;
            r_data    <= '0;
            r_par_en  <= 1'b0;
            r_par_typ <= PAR_EVEN;
        end else begin
            if (w_accept) begin
                r_data    <= P_DATA;
                r_par_en  <= PAR_EN;
                r_par_typ <= PAR_TYP;
            end

            unique case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_state <= ST_START;
                        r_tx    <= TX_START_LEVEL;
                        r_busy  <= 1'b1;
                    end else begin
                        r_tx    <= TX_IDLE_LEVEL;
                        r_busy  <= 1'b0;
                    end
                end

                ST_START: begin
                    r_state <= ST_DATA;
                    r_tx    <= w_ser_bit;
                end

                ST_DATA: begin
                    if (w_ser_done) begin
                        if (r_par_en) begin
                            r_state <= ST_PARITY;
                            r_tx    <= w_parity;
                        end else begin
                            r_state <= ST_STOP;
                            r_tx    <= TX_STOP_LEVEL;
                        end
                    end else begin
                        r_tx    <= w_ser_bit;
                    end
                end

                ST_PARITY: begin
                    r_state <= ST_STOP;
                    r_tx    <= TX_STOP_LEVEL;
                end

                ST_STOP: begin
                    if (w_accept) begin
                        // Back-to-back frame: start bit follows the stop bit
                        // directly and Busy stays asserted.
                        r_state <= ST_START;
                        r_tx    <= TX_START_LEVEL;
                        r_busy  <= 1'b1;
                    end else begin
                        r_state <= ST_IDLE;
                        r_tx    <= TX_IDLE_LEVEL;
                        r_busy  <= 1'b0;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                    r_tx    <= TX_IDLE_LEVEL;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign TX_OUT = r_tx;
    assign Busy   = r_busy;

endmodule : uart_tx

// File: tb/tb_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_uart_tx
//   Self-checking bench for uart_tx (DATA_WIDTH = 8).
//   The reference model keeps a queue of line levels still to be shown in
//   the current frame; a request is accepted when that queue is empty
//   (idle, or the stop bit is on the line) and appends a whole frame.
// -----------------------------------------------------------------------------
module tb_uart_tx;

    logic       CLK;
    logic       RST;
    logic [7:0] P_DATA;
    logic       Data_Valid;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic       TX_OUT;
    logic       Busy;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    bit   q[$];
    logic m_tx;
    logic m_busy;

    typedef struct {
        logic [7:0]  data;
        logic        par_en;
        logic        par_typ;
        logic [11:0] exp_tx;    // MSB = first cycle after the accept edge
        logic [11:0] exp_busy;
    } vec_t;

    vec_t tbl[4];

    uart_tx #(
        .DATA_WIDTH (8)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .P_DATA     (P_DATA),
        .Data_Valid (Data_Valid),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .TX_OUT     (TX_OUT),
        .Busy       (Busy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // A frame expressed as the sequence of line levels it produces.
    function automatic void push_frame(input logic [7:0] d, input logic pe, input logic pt);
        q.push_back(1'b0);
        for (int i = 0; i < 8; i++) q.push_back(d[i]);
        if (pe) q.push_back((($countones(d) % 2) == 1) ^ pt);
        q.push_back(1'b1);
    endfunction

    // One clock: model decides acceptance from the inputs presented before
    // the edge, then both model and DUT are compared 1 time unit after it.
    task automatic tick();
        if (!RST && Data_Valid && (q.size() == 0))
            push_frame(P_DATA, PAR_EN, PAR_TYP);
        @(posedge CLK);
        if (!RST && q.size() > 0) begin
            m_tx   = q.pop_front();
            m_busy = 1'b1;
        end else begin
            m_tx   = 1'b1;
            m_busy = 1'b0;
        end
        #1;
        check("model_tx", {31'b0, TX_OUT}, {31'b0, m_tx});
        check("model_busy", {31'b0, Busy}, {31'b0, m_busy});
    endtask

    task automatic async_reset();
        RST = 1'b1;
        q.delete();
        #1;
        check("rst_tx", {31'b0, TX_OUT}, 32'd1);
        check("rst_busy", {31'b0, Busy}, 32'd0);
        tick();
        RST = 1'b0;
    endtask

    // Single-pulse request followed by 12 observed cycles, compared as a whole.
    task automatic run_frame(input int idx, input string name);
        logic [11:0] a_tx;
        logic [11:0] a_busy;
        a_tx   = '0;
        a_busy = '0;
        P_DATA     = tbl[idx].data;
        PAR_EN     = tbl[idx].par_en;
        PAR_TYP    = tbl[idx].par_typ;
        Data_Valid = 1'b1;
        for (int c = 0; c < 12; c++) begin
            tick();
            Data_Valid = 1'b0;
            a_tx   = {a_tx[10:0], TX_OUT};
            a_busy = {a_busy[10:0], Busy};
        end
        check({name, "_tx"}, {20'b0, a_tx}, {20'b0, tbl[idx].exp_tx});
        check({name, "_busy"}, {20'b0, a_busy}, {20'b0, tbl[idx].exp_busy});
    endtask

    initial begin
        logic [20:0] b_tx;
        logic [20:0] b_busy;
        logic [11:0] c_tx;
        logic [11:0] c_busy;

        tbl[0] = '{8'hA5, 1'b1, 1'b0, 12'b010100101011, 12'b111111111110};
        tbl[1] = '{8'h01, 1'b1, 1'b1, 12'b010000000011, 12'b111111111110};
        tbl[2] = '{8'hFF, 1'b0, 1'b0, 12'b011111111111, 12'b111111111100};
        tbl[3] = '{8'h96, 1'b1, 1'b1, 12'b001101001111, 12'b111111111110};

        RST        = 1'b1;
        P_DATA     = '0;
        Data_Valid = 1'b0;
        PAR_EN     = 1'b0;
        PAR_TYP    = 1'b0;
        #3;
        check("reset_tx", {31'b0, TX_OUT}, 32'd1);
        check("reset_busy", {31'b0, Busy}, 32'd0);
        tick();
        RST = 1'b0;
        tick();

        // Table-driven isolated frames
        for (int v = 0; v < 4; v++) begin
            run_frame(v, $sformatf("vec%0d", v));
            tick();
        end

        // Back-to-back: level request, new word presented during STOP
        b_tx = '0;
        b_busy = '0;
        P_DATA = 8'h3C;
        PAR_EN = 1'b0;
        PAR_TYP = 1'b0;
        Data_Valid = 1'b1;
        for (int c = 0; c < 21; c++) begin
            tick();
            b_tx   = {b_tx[19:0], TX_OUT};
            b_busy = {b_busy[19:0], Busy};
            if (c == 9)  P_DATA = 8'hC3;
            if (c == 10) Data_Valid = 1'b0;
        end
        check("b2b_tx", {11'b0, b_tx}, {11'b0, 21'b000111100101100001111});
        check("b2b_busy", {11'b0, b_busy}, {11'b0, 21'b111111111111111111110});
        tick();

        // Request during DATA is dropped
        c_tx = '0;
        c_busy = '0;
        P_DATA = 8'h0F;
        PAR_EN = 1'b0;
        Data_Valid = 1'b1;
        for (int c = 0; c < 12; c++) begin
            tick();
            Data_Valid = 1'b0;
            if (c == 2) begin
                Data_Valid = 1'b1;
                P_DATA = 8'h55;
                PAR_EN = 1'b1;
            end
            c_tx   = {c_tx[10:0], TX_OUT};
            c_busy = {c_busy[10:0], Busy};
        end
        check("drop_tx", {20'b0, c_tx}, {20'b0, 12'b011110000111});
        check("drop_busy", {20'b0, c_busy}, {20'b0, 12'b111111111100});
        tick();

        // Reset during data bit 4, then a clean frame
        P_DATA = 8'hA5;
        PAR_EN = 1'b1;
        PAR_TYP = 1'b0;
        Data_Valid = 1'b1;
        for (int c = 0; c < 6; c++) begin
            tick();
            Data_Valid = 1'b0;
        end
        async_reset();
        tick();
        run_frame(0, "after_rst");

        // Randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 299) == 0) begin
                async_reset();
            end else begin
                Data_Valid = ($urandom_range(0, 3) == 0);
                P_DATA     = 8'($urandom);
                PAR_EN     = 1'($urandom);
                PAR_TYP    = 1'($urandom);
                tick();
            end
        end
        Data_Valid = 1'b0;
        for (int c = 0; c < 14; c++) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_uart_tx
